// File: rtl/store_buffer_pkg.sv
// Shared pipeline constants and the store-buffer entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_buffer_pkg;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB    = 3'b000;
  localparam logic [2:0] F3_SH    = 3'b001;
  localparam logic [2:0] F3_SW    = 3'b010;
  localparam int         SB_DEPTH = 4;

  // The address field holds the word address padded with 2'b00. That keeps
  // the entry at 68 bits and lets the head drive DM_waddr_out directly.
  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline and data-memory signals of the store buffer, grouped as one bundle.
// Latency: n/a (wiring only).
// Backpressure: ST_stall_out toward EX/MEM; DM_wvalid_out/DM_wready_in toward memory.
// master = pipeline/memory side, slave = store_buffer.
interface store_buffer_if;
  logic [6:0]  EM_op_in;
  logic [2:0]  EM_funct3_in;
  logic [31:0] EM_daddr_in;
  logic [31:0] EM_rs2data_in;
  logic        LD_valid_in;
  logic [31:0] LD_daddr_in;
  logic        ST_stall_out;
  logic        ST_fault_out;
  logic        LD_hazard_out;
  logic        SB_empty_out;
  logic        DM_wvalid_out;
  logic [31:0] DM_waddr_out;
  logic [31:0] DM_wdata_out;
  logic [3:0]  DM_wstrb_out;
  logic        DM_wready_in;

  modport master (
    output EM_op_in, EM_funct3_in, EM_daddr_in, EM_rs2data_in,
    output LD_valid_in, LD_daddr_in, DM_wready_in,
    input  ST_stall_out, ST_fault_out, LD_hazard_out, SB_empty_out,
    input  DM_wvalid_out, DM_waddr_out, DM_wdata_out, DM_wstrb_out
  );

  modport slave (
    input  EM_op_in, EM_funct3_in, EM_daddr_in, EM_rs2data_in,
    input  LD_valid_in, LD_daddr_in, DM_wready_in,
    output ST_stall_out, ST_fault_out, LD_hazard_out, SB_empty_out,
    output DM_wvalid_out, DM_waddr_out, DM_wdata_out, DM_wstrb_out
  );
endinterface

// File: rtl/store_fifo.sv
// Generic DEPTH x 68-bit synchronous FIFO that exposes per-entry valid bits and word addresses.
// Latency: a push at edge N is visible on head_dat after edge N (registered, no bypass).
// Backpressure: a push is dropped while full; a pop is ignored while empty.
// Ports: push_vld/push_dat write; pop_rdy pops the head; full/empty; entry_vld/entry_waddr feed hazard compares.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_vld,
  input  sb_entry_t       push_dat,
  input  logic            pop_rdy,
  output sb_entry_t       head_dat,
  output logic            full,
  output logic            empty,
  output logic [DEPTH-1:0] entry_vld,
  output logic [29:0]     entry_waddr [DEPTH]
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  sb_entry_t        mem [DEPTH];
  logic             push_en, pop_en;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO refuses the push even when the head pops on the same edge.
  assign push_en  = push_vld && !full;
  assign pop_en   = pop_rdy && !empty;
  assign head_dat = mem[rd_ptr];

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push_en) - (PTR_W+1)'(pop_en);
      // Push and pop never target the same slot: that would need the FIFO
      // to be both full and empty.
      if (pop_en)  entry_vld[rd_ptr] <= 1'b0;
      if (push_en) entry_vld[wr_ptr] <= 1'b1;
    end
  end

  // The payload has no reset. An entry is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_dat;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_waddr[i] = mem[i].waddr[31:2];
  end
endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns EX/MEM stores into byte lanes, queues them and drains them to data memory in order.
// Latency: a store accepted at edge N reaches DM_* after edge N (no bypass); the head drains when DM_wready_in is high.
// Backpressure: ST_stall_out while full; a faulting store neither stalls nor enqueues.
// Ports: clk, rst_n (async active-low), bus (store_buffer_if.slave): EM_*/LD_* in, ST_*/LD_hazard/SB_empty out, DM_* write channel.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  store_buffer_if.slave  bus
);
  logic             is_store, legal;
  logic [1:0]       off;
  logic [31:0]      lane_data;
  logic [3:0]       lane_strb;
  sb_entry_t        push_dat, head_dat;
  logic             full, empty, pop_rdy, addr_hit;
  logic [DEPTH-1:0] entry_vld;
  logic [29:0]      entry_waddr [DEPTH];
  logic             unused_ld_off;

  assign is_store = (bus.EM_op_in == OP_STORE);
  assign off      = bus.EM_daddr_in[1:0];

  // Replicate the store data across all byte lanes so that the strobe alone
  // selects the lanes to write.
  always_comb begin
    legal     = 1'b0;
    lane_data = bus.EM_rs2data_in;
    lane_strb = 4'b0000;
    case (bus.EM_funct3_in)
      F3_SB: begin
        legal     = 1'b1;
        lane_data = {4{bus.EM_rs2data_in[7:0]}};
        lane_strb = 4'b0001 << off;
      end
      F3_SH: begin
        legal     = !off[0];
        lane_data = {2{bus.EM_rs2data_in[15:0]}};
        lane_strb = 4'b0011 << off;
      end
      F3_SW: begin
        legal     = (off == 2'b00);
        lane_strb = 4'b1111;
      end
      default: ;
    endcase
  end

  assign push_dat = '{waddr: {bus.EM_daddr_in[31:2], 2'b00},
                      data:  lane_data,
                      strb:  lane_strb};

  assign bus.ST_fault_out = is_store && !legal;
  assign bus.ST_stall_out = is_store && legal && full;
  assign pop_rdy          = bus.DM_wvalid_out && bus.DM_wready_in;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_vld    (is_store && legal),
    .push_dat    (push_dat),
    .pop_rdy     (pop_rdy),
    .head_dat    (head_dat),
    .full        (full),
    .empty       (empty),
    .entry_vld   (entry_vld),
    .entry_waddr (entry_waddr)
  );

  assign bus.SB_empty_out  = empty;
  assign bus.DM_wvalid_out = !empty;
  assign bus.DM_waddr_out  = head_dat.waddr;
  assign bus.DM_wdata_out  = head_dat.data;
  assign bus.DM_wstrb_out  = head_dat.strb;

  // The head still counts this cycle, even while it is being popped.
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (entry_vld[i] && entry_waddr[i] == bus.LD_daddr_in[31:2]) addr_hit = 1'b1;
  end
  assign bus.LD_hazard_out = bus.LD_valid_in && addr_hit;

  // The hazard compare is word-granular, so the load's byte offset is not needed.
  assign unused_ld_off = ^bus.LD_daddr_in[1:0];
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_buffer_if sb_if ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;
  exp_t q[$];

  // Reference rules: lane data comes from multiplying by a replication constant.
  function automatic void model_store(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] rs2, output bit legal,
                                      output logic [31:0] d, output logic [3:0] s);
    int off;
    off = int'(addr % 4);
    legal = 0; d = '0; s = '0;
    if (f3 == 3'd0) begin
      legal = 1; d = rs2[7:0] * 32'h01010101; s = 4'(1 << off);
    end else if (f3 == 3'd1) begin
      legal = (off % 2 == 0); d = rs2[15:0] * 32'h00010001; s = 4'(3 << off);
    end else if (f3 == 3'd2) begin
      legal = (off == 0); d = rs2; s = 4'hF;
    end
  endfunction

  function automatic bit exp_hazard(input logic ldv, input logic [31:0] a);
    bit hit = 0;
    foreach (q[i]) if ((q[i].addr >> 2) == (a >> 2)) hit = 1;
    return ldv && hit;
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic ldv, input logic [31:0] ldaddr,
                       input logic wr);
    sb_if.EM_op_in      = op;
    sb_if.EM_funct3_in  = f3;
    sb_if.EM_daddr_in   = addr;
    sb_if.EM_rs2data_in = rs2;
    sb_if.LD_valid_in   = ldv;
    sb_if.LD_daddr_in   = ldaddr;
    sb_if.DM_wready_in  = wr;
  endtask

  // Advance one rising edge and apply it to the reference queue.
  task automatic model_edge();
    bit legal, do_push, do_pop;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] a;
    model_store(sb_if.EM_funct3_in, sb_if.EM_daddr_in, sb_if.EM_rs2data_in, legal, d, s);
    a       = sb_if.EM_daddr_in;
    do_push = (sb_if.EM_op_in == 7'b0100011) && legal && (q.size() < DEPTH);
    do_pop  = (q.size() > 0) && sb_if.DM_wready_in;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{addr: a & 32'hFFFF_FFFC, data: d, strb: s});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(7'b0100011, 3'd2, 32'h0, 32'h1, 1'b1, 32'h0, 1'b0);
    #12;
    checks++; if (sb_if.DM_wvalid_out !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", sb_if.DM_wvalid_out); end
    checks++; if (sb_if.SB_empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", sb_if.SB_empty_out); end
    checks++; if (sb_if.LD_hazard_out !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", sb_if.LD_hazard_out); end
    checks++; if (sb_if.ST_stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", sb_if.ST_stall_out); end
    @(negedge clk);
    drive(7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic test_sb_byte();
    @(negedge clk);
    drive(7'b0100011, 3'd0, 32'h1003, 32'h000000AB, 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (sb_if.ST_fault_out !== 1'b0) begin errors++; $display("FAIL sb_fault got %b exp 0", sb_if.ST_fault_out); end
    checks++; if (sb_if.DM_wvalid_out !== 1'b0) begin errors++; $display("FAIL sb_no_bypass got %b exp 0", sb_if.DM_wvalid_out); end
    model_edge();
    @(negedge clk);
    drive(7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (sb_if.DM_wvalid_out !== 1'b1) begin errors++; $display("FAIL sb_wvalid got %b exp 1", sb_if.DM_wvalid_out); end
    checks++; if (sb_if.DM_waddr_out !== 32'h1000) begin errors++; $display("FAIL sb_waddr got %h exp 00001000", sb_if.DM_waddr_out); end
    checks++; if (sb_if.DM_wdata_out !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h exp ababab ab", sb_if.DM_wdata_out); end
    checks++; if (sb_if.DM_wstrb_out !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %b exp 1000", sb_if.DM_wstrb_out); end
    model_edge();
    @(negedge clk); #1;
    checks++; if (sb_if.SB_empty_out !== 1'b1) begin errors++; $display("FAIL sb_popped got empty=%b exp 1", sb_if.SB_empty_out); end
  endtask

  task automatic test_faults();
    logic [2:0]  f3s [3];
    logic [31:0] adr [3];
    f3s = '{3'd1, 3'd2, 3'd3};
    adr = '{32'h2001, 32'h2002, 32'h2000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(7'b0100011, f3s[i], adr[i], 32'h12345678, 1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (sb_if.ST_fault_out !== 1'b1) begin errors++; $display("FAIL fault_%0d got %b exp 1", i, sb_if.ST_fault_out); end
      checks++; if (sb_if.ST_stall_out !== 1'b0) begin errors++; $display("FAIL fault_stall_%0d got %b exp 0", i, sb_if.ST_stall_out); end
      model_edge();
      @(negedge clk);
      drive(7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (sb_if.SB_empty_out !== 1'b1) begin errors++; $display("FAIL fault_empty_%0d got %b exp 1", i, sb_if.SB_empty_out); end
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] data [5];
    foreach (data[i]) data[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(7'b0100011, 3'd2, 32'h4000 + 32'(4 * i), data[i], 1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (sb_if.ST_stall_out !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d got %b exp 0", i, sb_if.ST_stall_out); end
      model_edge();
    end
    // The 5th store stalls; on k==2 the memory pops, but the push must still wait.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(7'b0100011, 3'd2, 32'h4010, data[4], 1'b0, 32'h0, k == 2);
      #1;
      checks++; if (sb_if.ST_stall_out !== 1'b1) begin errors++; $display("FAIL full_stall_%0d got %b exp 1", k, sb_if.ST_stall_out); end
      checks++; if (sb_if.DM_waddr_out !== 32'h4000 || sb_if.DM_wdata_out !== data[0])
        begin errors++; $display("FAIL full_stable_%0d got %h/%h exp 00004000/%h", k, sb_if.DM_waddr_out, sb_if.DM_wdata_out, data[0]); end
      model_edge();
    end
    @(negedge clk);
    drive(7'b0100011, 3'd2, 32'h4010, data[4], 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (sb_if.ST_stall_out !== 1'b0) begin errors++; $display("FAIL unstall got %b exp 0", sb_if.ST_stall_out); end
    model_edge();
    for (int c = 0; c < 12 && q.size() > 0; c++) begin
      @(negedge clk);
      drive(7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
      #1;
      checks++; if (sb_if.DM_wvalid_out !== 1'b1 || sb_if.DM_waddr_out !== q[0].addr || sb_if.DM_wdata_out !== q[0].data)
        begin errors++; $display("FAIL drain_order v=%b a=%h d=%h exp a=%h d=%h", sb_if.DM_wvalid_out, sb_if.DM_waddr_out, sb_if.DM_wdata_out, q[0].addr, q[0].data); end
      model_edge();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL drain_timeout left %0d exp 0", q.size()); end
    @(negedge clk); #1;
    checks++; if (sb_if.SB_empty_out !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", sb_if.SB_empty_out); end
  endtask

  task automatic test_push_pop_wrap();
    int drained = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(7'b0100011, 3'd2, 32'h5000 + 32'(4 * i), $urandom, 1'b0, 32'h0, 1'b0);
      model_edge();
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(7'b0100011, 3'd2, 32'h5100 + 32'(4 * k), $urandom, 1'b0, 32'h0, 1'b1);
      #1;
      checks++; if (sb_if.ST_stall_out !== 1'b0 || sb_if.DM_waddr_out !== q[0].addr || sb_if.DM_wdata_out !== q[0].data)
        begin errors++; $display("FAIL wrap_%0d stall=%b a=%h d=%h exp 0 %h %h", k, sb_if.ST_stall_out, sb_if.DM_waddr_out, sb_if.DM_wdata_out, q[0].addr, q[0].data); end
      model_edge();
    end
    for (int c = 0; c < 8 && sb_if.DM_wvalid_out === 1'b1; c++) begin
      @(negedge clk);
      drive(7'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
      #1;
      if (sb_if.DM_wvalid_out === 1'b1) begin
        drained++;
        checks++; if (q.size() == 0 || sb_if.DM_waddr_out !== q[0].addr)
          begin errors++; $display("FAIL wrap_drain got a=%h exp %h", sb_if.DM_waddr_out, (q.size() > 0) ? q[0].addr : 32'hx); end
      end
      model_edge();
    end
    checks++; if (drained != 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", drained); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    drive(7'b0100011, 3'd2, 32'h3000, 32'hCAFE0001, 1'b0, 32'h0, 1'b0);
    model_edge();
    @(negedge clk);
    drive(7'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h3002, 1'b0);
    #1;
    checks++; if (sb_if.LD_hazard_out !== 1'b1) begin errors++; $display("FAIL hz_match got %b exp 1", sb_if.LD_hazard_out); end
    sb_if.LD_daddr_in = 32'h3004; #1;
    checks++; if (sb_if.LD_hazard_out !== 1'b0) begin errors++; $display("FAIL hz_other got %b exp 0", sb_if.LD_hazard_out); end
    sb_if.LD_daddr_in = 32'h3002; sb_if.LD_valid_in = 1'b0; #1;
    checks++; if (sb_if.LD_hazard_out !== 1'b0) begin errors++; $display("FAIL hz_noload got %b exp 0", sb_if.LD_hazard_out); end
    @(negedge clk);
    drive(7'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h3002, 1'b1);
    #1;
    checks++; if (sb_if.LD_hazard_out !== 1'b1) begin errors++; $display("FAIL hz_popping got %b exp 1", sb_if.LD_hazard_out); end
    model_edge();
    @(negedge clk); #1;
    checks++; if (sb_if.LD_hazard_out !== 1'b0) begin errors++; $display("FAIL hz_after_pop got %b exp 0", sb_if.LD_hazard_out); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(7'b0100011, 3'd2, 32'h6000 + 32'(4 * i), $urandom, 1'b0, 32'h0, 1'b0);
      model_edge();
    end
    @(negedge clk);
    drive(7'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h6000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sb_if.DM_wvalid_out !== 1'b0) begin errors++; $display("FAIL rstmid_wvalid got %b exp 0", sb_if.DM_wvalid_out); end
    checks++; if (sb_if.SB_empty_out !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", sb_if.SB_empty_out); end
    checks++; if (sb_if.LD_hazard_out !== 1'b0) begin errors++; $display("FAIL rstmid_hazard got %b exp 0", sb_if.LD_hazard_out); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++; if (sb_if.DM_wvalid_out !== 1'b0) begin errors++; $display("FAIL rstmid_write_%0d got %b exp 0", c, sb_if.DM_wvalid_out); end
    end
  endtask

  task automatic test_random();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr, ld;
    bit legal, e_fault, e_stall;
    logic [31:0] d;
    logic [3:0]  s;
    int r;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      op = ($urandom_range(0, 9) < 7) ? 7'b0100011 : 7'b0000011;
      r  = $urandom_range(0, 7);
      f3 = (r < 6) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      addr = 32'h100 + 32'($urandom_range(0, 23));
      ld   = 32'h100 + 32'($urandom_range(0, 23));
      drive(op, f3, addr, $urandom, 1'($urandom_range(0, 1)), ld, 1'($urandom_range(0, 1)));
      #1;
      model_store(f3, addr, sb_if.EM_rs2data_in, legal, d, s);
      e_fault = (op == 7'b0100011) && !legal;
      e_stall = (op == 7'b0100011) && legal && (q.size() == DEPTH);
      checks++; if (sb_if.ST_fault_out !== e_fault) begin errors++; $display("FAIL rnd_fault[%0d] got %b exp %b", n, sb_if.ST_fault_out, e_fault); end
      checks++; if (sb_if.ST_stall_out !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %b exp %b", n, sb_if.ST_stall_out, e_stall); end
      checks++; if (sb_if.SB_empty_out !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty[%0d] got %b exp %b", n, sb_if.SB_empty_out, q.size() == 0); end
      checks++; if (sb_if.LD_hazard_out !== exp_hazard(sb_if.LD_valid_in, ld))
        begin errors++; $display("FAIL rnd_hazard[%0d] got %b exp %b", n, sb_if.LD_hazard_out, exp_hazard(sb_if.LD_valid_in, ld)); end
      if (q.size() > 0) begin
        checks++; if (sb_if.DM_wvalid_out !== 1'b1 || sb_if.DM_waddr_out !== q[0].addr || sb_if.DM_wdata_out !== q[0].data || sb_if.DM_wstrb_out !== q[0].strb)
          begin errors++; $display("FAIL rnd_head[%0d] got v=%b %h %h %b exp 1 %h %h %b", n, sb_if.DM_wvalid_out, sb_if.DM_waddr_out, sb_if.DM_wdata_out, sb_if.DM_wstrb_out, q[0].addr, q[0].data, q[0].strb); end
      end else begin
        checks++; if (sb_if.DM_wvalid_out !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d] got %b exp 0", n, sb_if.DM_wvalid_out); end
      end
      model_edge();
    end
  endtask

  initial begin
    test_reset();
    test_sb_byte();
    test_faults();
    test_full_stall();
    test_push_pop_wrap();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
